// File: rtl/alsu_pkg.sv
// Shared definitions for the ALSU command front end: command field layout,
// opcode values, the idle command and the arbiter FSM state encoding.
package alsu_pkg;

  localparam int CMD_BITS = 16;
  localparam int OUT_BITS = 6;

  // Packed command field offsets and widths
  localparam int OPND_W     = 3;
  localparam int OPC_W      = 3;
  localparam int A_LSB      = 13;
  localparam int B_LSB      = 10;
  localparam int OPC_LSB    = 7;
  localparam int CIN_BIT    = 6;
  localparam int SERIAL_BIT = 5;
  localparam int DIR_BIT    = 4;
  localparam int RED_A_BIT  = 3;
  localparam int RED_B_BIT  = 2;
  localparam int BYP_A_BIT  = 1;
  localparam int BYP_B_BIT  = 0;

  typedef enum logic [OPC_W-1:0] {
    OP_AND    = 3'd0,
    OP_XOR    = 3'd1,
    OP_ADD    = 3'd2,
    OP_MUL    = 3'd3,
    OP_SHIFT  = 3'd4,
    OP_ROTATE = 3'd5,
    OP_ILL6   = 3'd6,
    OP_ILL7   = 3'd7
  } opcode_e;

  // AND of A=0, B=0 with no bypass: harmless to repeat every cycle
  localparam logic [CMD_BITS-1:0] IDLE_CMD = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Opcodes 6 and 7 are answered locally and never reach the ALSU
  function automatic logic opcode_legal(input logic [OPC_W-1:0] opc);
    return opc <= OP_ROTATE;
  endfunction

endpackage

// File: rtl/alsu_rr_arb.sv
// Two-way round-robin arbiter. The requester served last loses a tie; a lone
// requester always wins. The pointer moves only when a grant is accepted.
module alsu_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_q;
  logic last_d;

  // Grant selection: a tie goes to the requester not served last
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_q ? 2'b01 : 2'b10;
    end
  end

  // Pointer follows the winner of an accepted grant
  always_comb begin
    last_d = last_q;
    if (accept) begin
      last_d = grant[1];
    end
  end

  // Pointer register; resetting to 1 lets req0 win the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/alsu_cmd_arbiter.sv
// Two-port command front end for the ALSU: arbitrates between two requesters,
// issues one command for exactly one cycle, waits out the ALSU latency,
// captures the result and returns it to the requester that sent it.
module alsu_cmd_arbiter
  import alsu_pkg::*;
#(
  parameter int ALSU_LAT = 2,
  parameter int CMD_W    = 16,
  parameter int OUT_W    = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [CMD_W-1:0] req0_cmd,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [CMD_W-1:0] req1_cmd,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [OUT_W-1:0] rsp_data,
  output logic             rsp_err,
  output logic [CMD_W-1:0] alsu_cmd,
  input  logic [OUT_W-1:0] alsu_out,
  input  logic [15:0]      alsu_leds,
  output logic             busy
);

  localparam int CNT_W = (ALSU_LAT > 1) ? $clog2(ALSU_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALSU_LAT - 1);

  state_e           state_q, state_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             err_q, err_d;

  logic [1:0]       grant;
  logic             accept;
  logic [CMD_W-1:0] sel_cmd;

  alsu_rr_arb u_arb (
    .clk    (CLK),
    .rst    (RST),
    .req    ({req1_valid, req0_valid}),
    .accept (accept),
    .grant  (grant)
  );

  // Handshake and output decode; reset suppresses any handshake in its cycle
  always_comb begin
    req0_ready = (state_q == ST_IDLE) && !RST && grant[0];
    req1_ready = (state_q == ST_IDLE) && !RST && grant[1];
    accept     = req0_ready || req1_ready;
    sel_cmd    = grant[1] ? req1_cmd : req0_cmd;
    rsp0_valid = (state_q == ST_RESP) && !id_q;
    rsp1_valid = (state_q == ST_RESP) && id_q;
    rsp_data   = data_q;
    rsp_err    = err_q;
    busy       = (state_q != ST_IDLE);
    alsu_cmd   = (state_q == ST_ISSUE) ? cmd_q : CMD_W'(IDLE_CMD);
  end

  // Next-state logic: accept, issue once, count down the latency, respond
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cmd_d = sel_cmd;
          id_d  = grant[1];
          if (opcode_legal(sel_cmd[OPC_LSB +: OPC_W])) begin
            state_d = ST_ISSUE;
          end else begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          data_d  = alsu_out;
          err_d   = |alsu_leds;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (id_q ? rsp1_ready : rsp0_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and capture registers; the latched command needs no reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
    cmd_q <= cmd_d;
    id_q  <= id_d;
  end

endmodule

// File: tb/tb_alsu_cmd_arbiter.sv
// Bench for alsu_cmd_arbiter with a cycle-accurate ALSU model (registered
// inputs and outputs, two cycles of latency) behind the command port.
module tb_alsu_cmd_arbiter;
  import alsu_pkg::*;

  localparam int LAT = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [15:0] req0_cmd, req1_cmd, alsu_cmd, alsu_leds;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [5:0]  rsp_data, alsu_out;
  logic        rsp_err, busy;

  alsu_cmd_arbiter #(.ALSU_LAT(LAT), .CMD_W(16), .OUT_W(6)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .alsu_cmd(alsu_cmd),
    .alsu_out(alsu_out), .alsu_leds(alsu_leds), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ALSU model: stateful out register so repeated shifts would accumulate
  function automatic logic [21:0] alsu_step(input logic [15:0] c, input logic [5:0] prev);
    logic [2:0] a, b, op;
    logic [5:0] r;
    a = c[15:13]; b = c[12:10]; op = c[9:7];
    if (((c[3] | c[2]) && op > 3'd1) || op > 3'd5) return {16'hFFFF, 6'd0};
    if (c[1]) return {16'h0, 3'd0, a};
    if (c[0]) return {16'h0, 3'd0, b};
    case (op)
      3'd0:    r = c[3] ? {5'd0, &a} : c[2] ? {5'd0, &b} : {3'd0, a & b};
      3'd1:    r = c[3] ? {5'd0, ^a} : c[2] ? {5'd0, ^b} : {3'd0, a ^ b};
      3'd2:    r = 6'(a) + 6'(b) + 6'(c[6]);
      3'd3:    r = 6'(a) * 6'(b);
      3'd4:    r = c[4] ? {prev[4:0], c[5]} : {c[5], prev[5:1]};
      default: r = c[4] ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
    endcase
    return {16'h0, r};
  endfunction

  logic [15:0] m_in;
  always @(posedge CLK) begin
    if (RST) begin
      m_in <= '0;
      {alsu_leds, alsu_out} <= '0;
    end else begin
      m_in <= alsu_cmd;
      {alsu_leds, alsu_out} <= alsu_step(m_in, alsu_out);
    end
  end

  // Reference: response of one command issued from an idle ALSU (out = 0)
  function automatic logic [6:0] expect_rsp(input logic [15:0] c);
    int a, b, op, v;
    a  = int'(c[A_LSB +: OPND_W]);
    b  = int'(c[B_LSB +: OPND_W]);
    op = int'(c[OPC_LSB +: OPC_W]);
    if (op >= 6) return {1'b1, 6'd0};
    if ((c[RED_A_BIT] || c[RED_B_BIT]) && op >= 2) return {1'b1, 6'd0};
    if (c[BYP_A_BIT]) return {1'b0, 6'(a)};
    if (c[BYP_B_BIT]) return {1'b0, 6'(b)};
    case (op)
      0:       v = c[RED_A_BIT] ? int'(a == 7) : c[RED_B_BIT] ? int'(b == 7) : (a & b);
      1:       v = c[RED_A_BIT] ? ($countones(a) % 2) : c[RED_B_BIT] ? ($countones(b) % 2) : (a ^ b);
      2:       v = a + b + int'(c[CIN_BIT]);
      3:       v = a * b;
      4:       v = c[DIR_BIT] ? int'(c[SERIAL_BIT]) : 32 * int'(c[SERIAL_BIT]);
      default: v = 0;
    endcase
    return {1'b0, 6'(v)};
  endfunction

  function automatic logic [15:0] mk_cmd(input int a, input int b, input int op,
                                         input bit cin, input bit sin, input bit dir);
    logic [15:0] c;
    c = '0;
    c[A_LSB +: OPND_W]  = 3'(a);
    c[B_LSB +: OPND_W]  = 3'(b);
    c[OPC_LSB +: OPC_W] = 3'(op);
    c[CIN_BIT]    = cin;
    c[SERIAL_BIT] = sin;
    c[DIR_BIT]    = dir;
    return c;
  endfunction

  typedef struct {
    int         port;
    logic [5:0] data;
    logic       err;
    int         due;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] feed0[$], feed1[$];
  logic [1:0]  exp_grant;
  logic        exp_busy;
  logic [15:0] exp_alsu;
  int          rdy_mode = 0;   // 0: always ready, 1: random, 2: rsp0 held low
  int          n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
  endtask

  // Requester and response-ready driver
  initial begin
    bit hs0, hs1;
    req0_valid = 0; req1_valid = 0; req0_cmd = '0; req1_cmd = '0;
    rsp0_ready = 1; rsp1_ready = 1;
    forever begin
      @(negedge CLK);
      hs0 = req0_valid && req0_ready && !RST;
      hs1 = req1_valid && req1_ready && !RST;
      @(posedge CLK); #1;
      if (hs0) req0_valid = 0;
      if (hs1) req1_valid = 0;
      if (!req0_valid && feed0.size() > 0) begin req0_cmd = feed0.pop_front(); req0_valid = 1; end
      if (!req1_valid && feed1.size() > 0) begin req1_cmd = feed1.pop_front(); req1_valid = 1; end
      case (rdy_mode)
        0:       begin rsp0_ready = 1; rsp1_ready = 1; end
        1:       begin rsp0_ready = 1'($urandom_range(0, 1)); rsp1_ready = 1'($urandom_range(0, 1)); end
        default: begin rsp0_ready = 0; rsp1_ready = 1; end
      endcase
    end
  end

  // Issue tracker: reference arbitration; pushes the expected response on accept
  initial begin
    bit          ref_last, ref_legal;
    int          p, issue_cyc;
    logic [15:0] c, issue_cmd;
    exp_t        e;
    ref_last = 1; ref_legal = 0; issue_cyc = -100; issue_cmd = '0;
    exp_grant = '0; exp_busy = 0; exp_alsu = '0;
    forever begin
      @(negedge CLK);
      exp_busy  = (exp_q.size() != 0);
      exp_alsu  = (exp_busy && ref_legal && cyc == issue_cyc + 1) ? issue_cmd : 16'h0;
      exp_grant = '0;
      if (RST) begin
        exp_q.delete();
        ref_last = 1;
      end else if (!exp_busy) begin
        if (req0_valid && req1_valid) p = ref_last ? 0 : 1;
        else if (req0_valid)          p = 0;
        else if (req1_valid)          p = 1;
        else                          p = -1;
        if (p >= 0) begin
          c = (p == 1) ? req1_cmd : req0_cmd;
          exp_grant = (p == 1) ? 2'b10 : 2'b01;
          ref_legal = (c[OPC_LSB +: OPC_W] < 3'd6);
          e.port = p;
          {e.err, e.data} = expect_rsp(c);
          e.due = ref_legal ? cyc + 2 + LAT : cyc + 1;
          exp_q.push_back(e);
          ref_last  = (p == 1);
          issue_cyc = cyc;
          issue_cmd = c;
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the tracker and pops responses
  initial begin
    bit         rst_prev;
    logic [1:0] expv;
    rst_prev = 0;
    forever begin
      @(negedge CLK); #1;
      if (RST) begin
        chk("req0_ready_in_reset", 32'(req0_ready), 32'(0));
        chk("req1_ready_in_reset", 32'(req1_ready), 32'(0));
        rst_prev = 1;
        continue;
      end
      if (rst_prev) begin
        chk("rsp_data_after_reset", 32'(rsp_data), 32'(0));
        chk("rsp_err_after_reset", 32'(rsp_err), 32'(0));
        rst_prev = 0;
      end
      chk("req_ready", 32'({req1_ready, req0_ready}), 32'(exp_grant));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("alsu_cmd", 32'(alsu_cmd), 32'(exp_alsu));
      expv = '0;
      if (exp_q.size() > 0 && cyc >= exp_q[0].due) expv = (exp_q[0].port == 1) ? 2'b10 : 2'b01;
      chk("rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'(expv));
      if (expv != 2'b00) begin
        chk("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
        chk("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
        if ((expv[0] && rsp0_ready) || (expv[1] && rsp1_ready)) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (feed0.size() == 0 && feed1.size() == 0 && !req0_valid && !req1_valid &&
          exp_q.size() == 0) return;
    end
    $display("FAIL drain_timeout: got busy after %0d cycles, required idle", budget);
    $fatal(1, "drain timeout");
  endtask

  initial begin
    logic [15:0] c;
    bit          seen;
    // Tie from reset: AND on req0 then XOR on req1
    feed0.push_back(mk_cmd(6, 3, OP_AND, 0, 0, 0));
    feed1.push_back(mk_cmd(6, 3, OP_XOR, 0, 0, 0));
    repeat (3) @(posedge CLK);
    #1 RST = 0;
    drain(200);
    // Single ADD
    feed0.push_back(mk_cmd(6, 3, OP_ADD, 0, 0, 0));
    drain(200);
    // Illegal opcode on req1
    feed1.push_back(mk_cmd(5, 2, OP_ILL7, 1, 0, 0));
    drain(200);
    // Response backpressure on rsp0 with req1 pending
    rdy_mode = 2;
    feed0.push_back(mk_cmd(5, 3, OP_MUL, 0, 0, 0));
    feed1.push_back(mk_cmd(4, 1, OP_ADD, 1, 0, 0));
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge CLK);
      seen = rsp0_valid;
    end
    if (!seen) begin
      $display("FAIL backpressure_wait: got no rsp0_valid, required rsp0_valid");
      $fatal(1, "wait expired");
    end
    repeat (5) @(posedge CLK);
    #1 rdy_mode = 0;
    drain(200);
    // Reset pulsed during WAIT
    feed0.push_back(mk_cmd(7, 7, OP_ADD, 1, 0, 0));
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge CLK);
      seen = req0_valid && req0_ready;
    end
    if (!seen) begin
      $display("FAIL reset_test_accept: got no accept, required accept");
      $fatal(1, "wait expired");
    end
    @(posedge CLK); #1;
    @(posedge CLK); #1 RST = 1;
    @(posedge CLK); #1 RST = 0;
    drain(200);
    // Shifts issued exactly once
    feed1.push_back(mk_cmd(3, 1, OP_SHIFT, 0, 1, 1));
    drain(200);
    feed0.push_back(mk_cmd(2, 5, OP_SHIFT, 0, 1, 0));
    drain(200);
    // Randomized traffic on both ports with random response backpressure
    rdy_mode = 1;
    for (int i = 0; i < 80; i++) begin
      c = 16'($urandom);
      c[OPC_LSB +: OPC_W] = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) c[3:0] = 4'd0;
      if ($urandom_range(0, 1) == 0) feed0.push_back(c);
      else                           feed1.push_back(c);
    end
    drain(4000);
    rdy_mode = 0;
    repeat (3) @(posedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alsu_cmd_arbiter.md
# alsu_cmd_arbiter

Two-port command front end for the ALSU. It accepts packed ALSU commands from two requesters over valid/ready handshakes, arbitrates round-robin, and drives one command at a time into the ALSU. It waits the ALSU pipeline latency, captures `out` and `leds`, and returns the result to the originating requester. It sits between the ALSU and its software/test-engine clients and is the only driver of the ALSU input pins.

## Interface
Parameters:
- `ALSU_LAT`, default 2. Cycles from the ALSU sampling a command to its result being visible on `alsu_out`. Legal range is ≥ 1.
- `CMD_W`, default 16. Packed command width; fixed by the package.
- `OUT_W`, default 6. ALSU result width.

Ports:
- `CLK`  in  1  Clock. Single clock domain, all logic on the rising edge.
- `RST`  in  1  Reset. Synchronous, active-high.
- `req0_valid` / `req1_valid`  in  1  Command offered.
- `req0_ready` / `req1_ready`  out  1  Command accepted this cycle.
- `req0_cmd` / `req1_cmd`  in  16  Packed command: [15:13] A, [12:10] B, [9:7] opcode, [6] cin, [5] serial_in, [4] direction, [3] red_op_A, [2] red_op_B, [1] bypass_A, [0] bypass_B.
- `rsp0_valid` / `rsp1_valid`  out  1  Result available.
- `rsp0_ready` / `rsp1_ready`  in  1  Result consumed.
- `rsp_data`  out  6  Captured result, shared by both response ports.
- `rsp_err`  out  1  Error flag for the returned result.
- `alsu_cmd`  out  16  Packed command to the ALSU, same layout as `req*_cmd`.
- `alsu_out`  in  6  ALSU `out`.
- `alsu_leds`  in  16  ALSU `leds`.
- `busy`  out  1  High whenever the FSM is not in IDLE.

## Operation
FSM states are IDLE, ISSUE, WAIT and RESP.

- **IDLE**
  - The arbiter grants one valid requester and raises that requester's `req_ready` combinationally.
  - On the handshake the block latches the command and the requester ID, then moves to:
    - ISSUE if the opcode is 0–5;
    - RESP directly if the opcode is 6 or 7, with `rsp_data`=0 and `rsp_err`=1. Illegal opcodes are never sent to the ALSU.
- **ISSUE** (one cycle)
  - `alsu_cmd` carries the latched command.
  - Next state is WAIT and the latency counter loads `ALSU_LAT`-1.
- **WAIT**
  - `alsu_cmd` = IDLE_CMD (all zeros, i.e. AND with no bypass). This keeps the shift and rotate opcodes from being re-applied.
  - The counter decrements each cycle.
  - In the cycle where the counter is 0, the block captures `rsp_data`=`alsu_out` and `rsp_err`=|`alsu_leds`, then moves to RESP.
- **RESP**
  - The originating `rspN_valid` is held high with `rsp_data` and `rsp_err` stable.
  - On `rspN_ready` the FSM returns to IDLE. The other response port stays low.

Arbitration:
- Two-way round-robin. The `last` pointer resets to 1, so `req0` wins the first tie.
- When both requesters are valid, the one not served last is granted.
- When only one is valid, it is granted regardless of the pointer.
- The pointer updates only on an accepted command.
- Both `req_ready` signals are 0 outside IDLE. A requester may drop `valid` before `ready` without any side effect.

## Timing
- Reset values: FSM in IDLE; `busy`=0; all `req*_ready`=0 (until the first IDLE evaluation); all `rsp*_valid`=0; `rsp_data`=0; `rsp_err`=0; `alsu_cmd`=IDLE_CMD; `last`=1.
- Accept in cycle *t* leads to:
  - ISSUE in *t*+1;
  - capture in cycle *t*+1+`ALSU_LAT`;
  - `rsp_valid` from *t*+2+`ALSU_LAT`.
- With `ALSU_LAT`=2, `rsp_valid` rises 4 cycles after accept.
- Minimum issue-to-issue interval is `ALSU_LAT`+3 cycles, with `rsp_ready` held high.
- Illegal opcode: `rsp_valid` rises in *t*+1.
- A new request arriving while the block is busy waits. No command is lost, and `cmd` must stay stable while `valid` is high and `ready` is low.
- `RST` asserted in any state takes effect at the next edge:
  - the in-flight operation is discarded, with no response;
  - `rsp_valid` drops;
  - `alsu_cmd` becomes IDLE_CMD.
- `RST` takes priority over every handshake in the same cycle.

## Structure
- The shared package `alsu_pkg` holds:
  - command field offsets and widths;
  - opcode constants: OP_AND=0, OP_XOR=1, OP_ADD=2, OP_MUL=3, OP_SHIFT=4, OP_ROTATE=5, OP_ILL6=6, OP_ILL7=7;
  - IDLE_CMD;
  - the FSM state encoding.
- One sub-module, `alsu_rr_arb`: a 2-way round-robin arbiter with inputs `req[1:0]` and `accept`, and output one-hot `grant[1:0]`.
- The FSM, latency counter and capture registers live in `alsu_cmd_arbiter`.

## Test plan
Bench: `ALSU_LAT`=2, with a real ALSU instance or a cycle-accurate model behind `alsu_cmd`/`alsu_out`.

1. **Single ADD.** `req0`: A=6, B=3, opcode=2, cin=0. Expect `rsp0_valid` 4 cycles after accept, `rsp_data`=9, `rsp_err`=0.
2. **Tie, then alternation.** Both requesters valid from reset: `req0` AND 6&3, `req1` XOR 6^3.
   - Grant order is `req0` then `req1`.
   - Expect `rsp_data`=2 on `rsp0` and 5 on `rsp1`.
   - If `req0` re-asserts with `req1` also still pending, `req1` is served next.
3. **Illegal opcode.** `req1`: opcode=7. Expect `rsp1_valid` the cycle after accept, `rsp_data`=0, `rsp_err`=1, and `alsu_cmd` never leaves IDLE_CMD.
4. **Response backpressure.** `rsp0_ready` held low for 5 cycles.
   - `rsp0_valid`, `rsp_data` and `rsp_err` stay stable.
   - `req1_valid` gets no `ready` until the cycle after `rsp0_ready` rises.
5. **Reset mid-operation.** `RST` pulsed during WAIT. The next cycle shows IDLE, `busy`=0, `rsp*_valid`=0, `alsu_cmd`=IDLE_CMD, and no response is ever produced for that command.
6. **Shift issued once.** SHIFT (opcode 4, direction=1, serial_in=1). `alsu_cmd` carries opcode 4 for exactly one cycle, so the ALSU shifts exactly once. Check the captured value against a single-shift model.
